press_classifier: RTL and testbench
===================================

PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 Parameter counterwidth, default 4: width in bits of the internal timing counter; SHALL satisfy 2^counterwidth > max(longtime, dblwindow).
REQ-002 Parameter longtime, default 8: hold duration in clock cycles that qualifies a long press.
REQ-003 Parameter dblwindow, default 6: release-to-second-press window in clock cycles that qualifies a double press.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 conditioned  input  1  debounced, synchronized button level from the input conditioner.
REQ-007 positiveedge  input  1  one-cycle pulse at the rising edge of conditioned.
REQ-008 negativeedge  input  1  one-cycle pulse at the falling edge of conditioned.
REQ-009 shortpress  output  1  registered one-cycle pulse marking a completed single short press.
REQ-010 longpress  output  1  registered one-cycle pulse at the moment a press qualifies as long.
REQ-011 doublepress  output  1  registered one-cycle pulse marking a completed double press.
REQ-012 held  output  1  registered level, high while a qualified long press is still held.
REQ-013 busy  output  1  registered level, high whenever the FSM is not IDLE.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, PRESS1, LONGHELD, WAITSECOND and PRESS2, plus a counter that loads 0 on every state entry and increments by 1 on each later clock in that state, with no wrap.
REQ-015 IDLE: a positiveedge SHALL cause a move to PRESS1; a negativeedge SHALL be ignored.
REQ-016 PRESS1: a negativeedge SHALL cause a move to WAITSECOND; otherwise, when counter == longtime, the block SHALL move to LONGHELD and pulse longpress.
REQ-017 PRESS1 edge-versus-timeout tie: when negativeedge coincides with counter == longtime, the release SHALL win (move to WAITSECOND, no longpress).
REQ-018 LONGHELD: held SHALL be 1; a negativeedge SHALL cause a move to IDLE with held returning to 0 on the same edge; no shortpress or doublepress SHALL be produced.
REQ-019 WAITSECOND: a positiveedge SHALL cause a move to PRESS2; otherwise, when counter == dblwindow, the block SHALL pulse shortpress and move to IDLE.
REQ-020 WAITSECOND edge-versus-timeout tie: when positiveedge coincides with counter == dblwindow, the press SHALL win (move to PRESS2, no shortpress).
REQ-021 PRESS2: a negativeedge SHALL pulse doublepress and cause a move to IDLE, regardless of the second press duration; no longpress SHALL be produced in PRESS2.
REQ-022 Latency: every output pulse SHALL be high for exactly the one cycle following the clock edge at which its triggering condition is sampled.
REQ-023 At most one of shortpress, longpress and doublepress SHALL be high in any cycle.
REQ-024 Edge pulses not listed for the current state (e.g. positiveedge in PRESS1 or LONGHELD) SHALL be ignored; the conditioned input SHALL be used for no decisions other than those stated.
REQ-025 busy SHALL equal (state != IDLE) as registered alongside the state.

Reset
REQ-026 When reset is sampled high, the block SHALL on that edge move to IDLE, clear the counter, and drive shortpress, longpress, doublepress, held and busy to 0, overriding all other inputs.
REQ-027 A reset asserted mid-sequence (any non-IDLE state) SHALL discard the sequence without emitting any pulse, including one whose trigger coincides with reset.
REQ-028 After reset deasserts, a positiveedge on the first following edge SHALL be accepted normally.

Verification (longtime=8, dblwindow=6, counterwidth=4)
REQ-029 Sequence: positiveedge at E0, negativeedge at E3, no further edges -> shortpress high in the cycle after E9 only, busy low after E9.
REQ-030 Sequence: positiveedge at E0, conditioned held high -> longpress pulse after E8 and held=1 from E8; negativeedge at E20 -> held=0 after E20, and no other pulses occur.
REQ-031 Sequence: positiveedge at E0, negativeedge at E2, positiveedge at E5, negativeedge at E30 -> doublepress pulse after E30 only, with no shortpress or longpress.
REQ-032 Tie cases: negativeedge at E8 after positiveedge at E0 -> no longpress, enters WAITSECOND; positiveedge exactly at the dblwindow timeout -> no shortpress, enters PRESS2.
REQ-033 Reset case: reset high at E5 during LONGHELD or WAITSECOND -> all outputs 0 after E5, no pulse, IDLE; a positiveedge at E6 -> busy=1 after E6.

Source files
------------

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced button presses as short, long or double
// Outputs are registered one-cycle pulses plus held/busy levels.
module press_classifier #(
    parameter int counterwidth = 4,
    parameter int longtime     = 8,
    parameter int dblwindow    = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic conditioned,
    input  logic positiveedge,
    input  logic negativeedge,
    output logic shortpress,
    output logic longpress,
    output logic doublepress,
    output logic held,
    output logic busy
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] PRESS1     = 3'd1;
    localparam logic [2:0] LONGHELD   = 3'd2;
    localparam logic [2:0] WAITSECOND = 3'd3;
    localparam logic [2:0] PRESS2     = 3'd4;

    // The counter reads k-1 at the k-th edge after state entry, so a timeout of N
    // fires on the N-th edge after entering the state.
    localparam logic [counterwidth-1:0] LONG_LAST = counterwidth'(longtime - 1);
    localparam logic [counterwidth-1:0] DBL_LAST  = counterwidth'(dblwindow - 1);
    localparam logic [counterwidth-1:0] CNT_MAX   = {counterwidth{1'b1}};

    logic [2:0]              state_q, state_d;
    logic [counterwidth-1:0] cnt_q, cnt_d;
    logic                    short_q, short_d;
    logic                    long_q, long_d;
    logic                    dbl_q, dbl_d;
    logic                    held_q, held_d;
    logic                    busy_q, busy_d;

    // The level input is available for future use but drives no decision.
    logic cond_unused;
    assign cond_unused = conditioned;

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (positiveedge) state_d = PRESS1;
            end
            PRESS1: begin
                if (negativeedge) begin
                    state_d = WAITSECOND;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONGHELD;
                    long_d  = 1'b1;
                end
            end
            LONGHELD: begin
                if (negativeedge) state_d = IDLE;
            end
            WAITSECOND: begin
                if (positiveedge) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (negativeedge) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        held_d = (state_d == LONGHELD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
            held_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
            held_q  <= held_d;
            busy_q  <= busy_d;
        end
    end

    assign shortpress  = short_q;
    assign longpress   = long_q;
    assign doublepress = dbl_q;
    assign held        = held_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - scoreboard bench for press_classifier
module tb_press_classifier;

    logic clk = 1'b0;
    logic reset;
    logic conditioned;
    logic positiveedge;
    logic negativeedge;
    logic shortpress;
    logic longpress;
    logic doublepress;
    logic held;
    logic busy;

    press_classifier #(
        .counterwidth(4),
        .longtime    (8),
        .dblwindow   (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .shortpress  (shortpress),
        .longpress   (longpress),
        .doublepress (doublepress),
        .held        (held),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    localparam int K_SHORT = 1;
    localparam int K_LONG  = 2;
    localparam int K_DBL   = 3;

    typedef struct {
        int kind;
        int e;
    } ev_t;

    typedef struct {
        int   e;
        logic h;
        logic b;
    } lv_t;

    ev_t exp_q[$];
    lv_t lv_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs seen at the negedge after edge number cyc.
    always @(negedge clk) begin
        int   kind;
        ev_t  ev;
        lv_t  lv;
        while (exp_q.size() > 0 && exp_q[0].e < cyc) begin
            ev = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_pulse kind=%0d: got none, required at edge %0d", ev.kind, ev.e);
        end
        if (shortpress || longpress || doublepress) begin
            checks++;
            if ($countones({shortpress, longpress, doublepress}) > 1) begin
                errors++;
                $display("FAIL onehot: got s/l/d=%b%b%b at edge %0d, required at most one",
                         shortpress, longpress, doublepress, cyc);
            end
            kind = shortpress ? K_SHORT : (longpress ? K_LONG : K_DBL);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got kind=%0d at edge %0d, required none", kind, cyc);
            end else begin
                ev = exp_q.pop_front();
                if (ev.kind != kind || ev.e != cyc) begin
                    errors++;
                    $display("FAIL pulse: got kind=%0d at edge %0d, required kind=%0d at edge %0d",
                             kind, cyc, ev.kind, ev.e);
                end
            end
        end
        while (lv_q.size() > 0 && lv_q[0].e <= cyc) begin
            lv = lv_q.pop_front();
            checks++;
            if (held !== lv.h || busy !== lv.b) begin
                errors++;
                $display("FAIL levels at edge %0d: got held=%b busy=%b, required held=%b busy=%b",
                         cyc, held, busy, lv.h, lv.b);
            end
        end
    end

    task automatic exp_pulse(input int kind, input int e);
        ev_t ev;
        ev.kind = kind;
        ev.e    = e;
        exp_q.push_back(ev);
    endtask

    task automatic exp_lvl(input int e, input logic h, input logic b);
        lv_t lv;
        lv.e = e;
        lv.h = h;
        lv.b = b;
        lv_q.push_back(lv);
    endtask

    // Relative edge indices for up to two rising/falling pulses and one reset (-1 = none).
    task automatic drive(input int n, input int pa, input int pb, input int na, input int nb,
                         input int rr);
        for (int i = 0; i < n; i++) begin
            positiveedge = (i == pa) || (i == pb);
            negativeedge = (i == na) || (i == nb);
            reset        = (i == rr);
            if (positiveedge) conditioned = 1'b1;
            if (negativeedge) conditioned = 1'b0;
            @(negedge clk);
        end
        positiveedge = 1'b0;
        negativeedge = 1'b0;
        reset        = 1'b0;
    endtask

    initial begin
        int b;
        reset        = 1'b1;
        conditioned  = 1'b0;
        positiveedge = 1'b0;
        negativeedge = 1'b1;
        exp_lvl(1, 1'b0, 1'b0);
        exp_lvl(2, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        reset        = 1'b0;
        negativeedge = 1'b0;

        // negativeedge in IDLE is ignored
        b = cyc + 1;
        exp_lvl(b, 1'b0, 1'b0);
        drive(3, -1, -1, 0, -1, -1);

        // short press
        b = cyc + 1;
        exp_lvl(b, 1'b0, 1'b1);
        exp_lvl(b + 8, 1'b0, 1'b1);
        exp_lvl(b + 9, 1'b0, 1'b0);
        exp_pulse(K_SHORT, b + 9);
        drive(14, 0, -1, 3, -1, -1);

        // long press, extra positiveedge in LONGHELD ignored
        b = cyc + 1;
        exp_lvl(b + 7, 1'b0, 1'b1);
        exp_lvl(b + 8, 1'b1, 1'b1);
        exp_lvl(b + 19, 1'b1, 1'b1);
        exp_lvl(b + 20, 1'b0, 1'b0);
        exp_pulse(K_LONG, b + 8);
        drive(24, 0, 12, 20, -1, -1);

        // double press with a long second hold
        b = cyc + 1;
        exp_lvl(b + 29, 1'b0, 1'b1);
        exp_lvl(b + 30, 1'b0, 1'b0);
        exp_pulse(K_DBL, b + 30);
        drive(34, 0, 5, 2, 30, -1);

        // release ties with long timeout: release wins, then short press
        b = cyc + 1;
        exp_lvl(b + 8, 1'b0, 1'b1);
        exp_lvl(b + 13, 1'b0, 1'b1);
        exp_pulse(K_SHORT, b + 14);
        drive(18, 0, -1, 8, -1, -1);

        // second press ties with double-window timeout: press wins
        b = cyc + 1;
        exp_lvl(b + 8, 1'b0, 1'b1);
        exp_pulse(K_DBL, b + 10);
        drive(14, 0, 8, 2, 10, -1);

        // reset during LONGHELD, then a fresh press right after
        b = cyc + 1;
        exp_pulse(K_LONG, b + 8);
        exp_lvl(b + 11, 1'b1, 1'b1);
        exp_lvl(b + 12, 1'b0, 1'b0);
        exp_lvl(b + 13, 1'b0, 1'b1);
        exp_pulse(K_SHORT, b + 21);
        drive(24, 0, 13, 12, 15, 12);

        // reset coincides with the short-press timeout in WAITSECOND
        b = cyc + 1;
        exp_lvl(b + 9, 1'b0, 1'b0);
        exp_lvl(b + 10, 1'b0, 1'b1);
        exp_pulse(K_SHORT, b + 17);
        drive(20, 0, 10, 3, 11, 9);

        // reset coincides with the double-press release
        b = cyc + 1;
        exp_lvl(b + 5, 1'b0, 1'b1);
        exp_lvl(b + 6, 1'b0, 1'b0);
        drive(9, 0, 4, 2, 6, 6);

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses: got %0d left, required 0", exp_q.size());
        end
        checks++;
        if (lv_q.size() != 0) begin
            errors++;
            $display("FAIL pending_levels: got %0d left, required 0", lv_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule
